// File: rtl/tlc_sequencer.sv
// Two-way intersection traffic-light sequencer with pedestrian walk phase and
// night flashing mode. Advances on a one-cycle sec_tick; every output is registered.
module tlc_sequencer #(
  parameter int unsigned NS_GREEN_SEC = 20,
  parameter int unsigned EW_GREEN_SEC = 15,
  parameter int unsigned YELLOW_SEC   = 3,
  parameter int unsigned ALLRED_SEC   = 1,
  parameter int unsigned WALK_SEC     = 10,
  parameter int unsigned CNT_W        = 6
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sec_tick,
  input  logic             ped_req,
  input  logic             night_mode,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic             walk,
  output logic             ped_pending,
  output logic [CNT_W-1:0] secs_left,
  output logic [2:0]       state_out
);

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    AR1   = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    AR2   = 3'd5,
    WALK  = 3'd6,
    FLASH = 3'd7
  } state_t;

  state_t           r_state, w_nxt_state;
  logic [CNT_W-1:0] r_cnt, w_nxt_cnt;
  logic             r_blink, w_nxt_blink;
  logic             r_ped, w_nxt_ped;
  logic [2:0]       r_ns, r_ew;
  logic             r_walk;
  logic [5:0]       w_lamps;

  // FLASH has no countdown; its counter sits at 0 so the display reads 0.
  function automatic logic [CNT_W-1:0] dur(input state_t s);
    case (s)
      NS_G:    dur = CNT_W'(NS_GREEN_SEC);
      EW_G:    dur = CNT_W'(EW_GREEN_SEC);
      NS_Y,
      EW_Y:    dur = CNT_W'(YELLOW_SEC);
      AR1,
      AR2:     dur = CNT_W'(ALLRED_SEC);
      WALK:    dur = CNT_W'(WALK_SEC);
      default: dur = '0;
    endcase
  endfunction

  function automatic logic [5:0] lamps(input state_t s, input logic b);
    case (s)
      NS_G:    lamps = {3'b001, 3'b100};
      NS_Y:    lamps = {3'b010, 3'b100};
      EW_G:    lamps = {3'b100, 3'b001};
      EW_Y:    lamps = {3'b100, 3'b010};
      FLASH:   lamps = {1'b0, b, 1'b0, b, 2'b00};
      default: lamps = {3'b100, 3'b100};
    endcase
  endfunction

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_blink = r_blink;
    w_nxt_ped   = r_ped | ped_req;
    if (sec_tick) begin
      if (r_state == FLASH) begin
        if (night_mode) begin
          w_nxt_blink = ~r_blink;
        end else begin
          w_nxt_state = AR2;
          w_nxt_cnt   = CNT_W'(ALLRED_SEC);
          w_nxt_blink = 1'b0;
        end
      end else if (r_cnt == CNT_W'(1)) begin
        case (r_state)
          NS_G:    w_nxt_state = NS_Y;
          NS_Y:    w_nxt_state = AR1;
          AR1:     w_nxt_state = night_mode ? FLASH : EW_G;
          EW_G:    w_nxt_state = EW_Y;
          EW_Y:    w_nxt_state = AR2;
          AR2:     w_nxt_state = night_mode ? FLASH : (r_ped ? WALK : NS_G);
          default: w_nxt_state = NS_G;
        endcase
        w_nxt_cnt   = dur(w_nxt_state);
        w_nxt_blink = (w_nxt_state == FLASH);
      end else begin
        w_nxt_cnt = r_cnt - CNT_W'(1);
      end
    end
    // A request arriving in the WALK-entry cycle is considered served.
    if (w_nxt_state == WALK && r_state != WALK) w_nxt_ped = 1'b0;
  end

  assign w_lamps = lamps(w_nxt_state, w_nxt_blink);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state <= AR2;
      r_cnt   <= CNT_W'(ALLRED_SEC);
      r_blink <= 1'b0;
      r_ped   <= 1'b0;
      r_ns    <= 3'b100;
      r_ew    <= 3'b100;
      r_walk  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_blink <= w_nxt_blink;
      r_ped   <= w_nxt_ped;
      r_ns    <= w_lamps[5:3];
      r_ew    <= w_lamps[2:0];
      r_walk  <= (w_nxt_state == WALK);
    end
  end

  assign ns_light    = r_ns;
  assign ew_light    = r_ew;
  assign walk        = r_walk;
  assign ped_pending = r_ped;
  assign secs_left   = r_cnt;
  assign state_out   = r_state;

endmodule

// File: tb/tb_tlc_sequencer.sv
// Directed bench for tlc_sequencer with short durations: a table of per-tick
// vectors plus hand sequences for async reset and a continuously-high tick.
module tb_tlc_sequencer;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       sec_tick = 1'b0;
  logic       ped_req = 1'b0;
  logic       night_mode = 1'b0;
  logic [2:0] ns_light, ew_light, state_out;
  logic       walk, ped_pending;
  logic [5:0] secs_left;

  int n_pass = 0;
  int n_total = 0;

  tlc_sequencer #(
    .NS_GREEN_SEC(3), .EW_GREEN_SEC(2), .YELLOW_SEC(2),
    .ALLRED_SEC(1), .WALK_SEC(2), .CNT_W(6)
  ) dut (
    .clk_in(clk_in), .rst(rst), .sec_tick(sec_tick), .ped_req(ped_req),
    .night_mode(night_mode), .ns_light(ns_light), .ew_light(ew_light),
    .walk(walk), .ped_pending(ped_pending), .secs_left(secs_left),
    .state_out(state_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic       ped;
    logic       night;
    logic [2:0] st;
    logic [5:0] sec;
    logic [2:0] ns;
    logic [2:0] ew;
    logic       wk;
    logic       pd;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
  endtask

  task automatic add(input logic p, input logic n, input logic [2:0] st, input logic [5:0] sec,
                     input logic [2:0] ns, input logic [2:0] ew, input logic wk, input logic pd);
    vec_t v;
    v.ped = p; v.night = n; v.st = st; v.sec = sec;
    v.ns = ns; v.ew = ew; v.wk = wk; v.pd = pd;
    vt.push_back(v);
  endtask

  task automatic do_tick();
    @(negedge clk_in) sec_tick = 1'b1;
    @(negedge clk_in) sec_tick = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic pulse_ped();
    @(negedge clk_in) ped_req = 1'b1;
    @(negedge clk_in) ped_req = 1'b0;
  endtask

  // Lamp safety: never two non-red approaches; in FLASH, EW is red or dark only.
  always @(negedge clk_in) begin
    if (!rst) begin
      if (state_out == 3'd7) chk("flash_ew_safe", 0, {29'd0, ew_light}, {29'd0, ew_light[2], 2'b00});
      else chk("no_conflict", 0, {31'd0, (ns_light == 3'b100 || ew_light == 3'b100)}, 32'd1);
    end
  end

  initial begin
    logic [2:0] exp_seq [12];
    // Plain sequence from reset, no requests.
    add(0,0,0,3,3'b001,3'b100,0,0); add(0,0,0,2,3'b001,3'b100,0,0);
    add(0,0,0,1,3'b001,3'b100,0,0); add(0,0,1,2,3'b010,3'b100,0,0);
    add(0,0,1,1,3'b010,3'b100,0,0); add(0,0,2,1,3'b100,3'b100,0,0);
    add(0,0,3,2,3'b100,3'b001,0,0); add(0,0,3,1,3'b100,3'b001,0,0);
    add(0,0,4,2,3'b100,3'b010,0,0); add(0,0,4,1,3'b100,3'b010,0,0);
    add(0,0,5,1,3'b100,3'b100,0,0); add(0,0,0,3,3'b001,3'b100,0,0);
    // Pedestrian pulse during NS_G, served at AR2 exit.
    add(1,0,0,2,3'b001,3'b100,0,1); add(0,0,0,1,3'b001,3'b100,0,1);
    add(0,0,1,2,3'b010,3'b100,0,1); add(0,0,1,1,3'b010,3'b100,0,1);
    add(0,0,2,1,3'b100,3'b100,0,1); add(0,0,3,2,3'b100,3'b001,0,1);
    add(0,0,3,1,3'b100,3'b001,0,1); add(0,0,4,2,3'b100,3'b010,0,1);
    add(0,0,4,1,3'b100,3'b010,0,1); add(0,0,5,1,3'b100,3'b100,0,1);
    add(0,0,6,2,3'b100,3'b100,1,0); add(0,0,6,1,3'b100,3'b100,1,0);
    add(0,0,0,3,3'b001,3'b100,0,0);
    // Night mode raised mid EW_G; green/yellow complete, FLASH at AR2 exit.
    add(0,0,0,2,3'b001,3'b100,0,0); add(0,0,0,1,3'b001,3'b100,0,0);
    add(0,0,1,2,3'b010,3'b100,0,0); add(0,0,1,1,3'b010,3'b100,0,0);
    add(0,0,2,1,3'b100,3'b100,0,0); add(0,0,3,2,3'b100,3'b001,0,0);
    add(0,1,3,1,3'b100,3'b001,0,0); add(0,1,4,2,3'b100,3'b010,0,0);
    add(0,1,4,1,3'b100,3'b010,0,0); add(0,1,5,1,3'b100,3'b100,0,0);
    add(0,1,7,0,3'b010,3'b100,0,0); add(0,1,7,0,3'b000,3'b000,0,0);
    add(0,1,7,0,3'b010,3'b100,0,0); add(0,0,5,1,3'b100,3'b100,0,0);
    add(0,0,0,3,3'b001,3'b100,0,0);
    // Night and pedestrian together at AR2 exit: night wins, request held.
    add(0,0,0,2,3'b001,3'b100,0,0); add(0,0,0,1,3'b001,3'b100,0,0);
    add(0,0,1,2,3'b010,3'b100,0,0); add(0,0,1,1,3'b010,3'b100,0,0);
    add(0,0,2,1,3'b100,3'b100,0,0); add(0,0,3,2,3'b100,3'b001,0,0);
    add(0,0,3,1,3'b100,3'b001,0,0); add(0,0,4,2,3'b100,3'b010,0,0);
    add(0,0,4,1,3'b100,3'b010,0,0); add(0,0,5,1,3'b100,3'b100,0,0);
    add(1,1,7,0,3'b010,3'b100,0,1); add(0,1,7,0,3'b000,3'b000,0,1);
    add(0,0,5,1,3'b100,3'b100,0,1); add(0,0,6,2,3'b100,3'b100,1,0);
    add(0,0,6,1,3'b100,3'b100,1,0); add(0,0,0,3,3'b001,3'b100,0,0);

    repeat (3) @(negedge clk_in);
    chk("rst_state", 0, {29'd0, state_out}, 32'd5);
    chk("rst_secs", 0, {26'd0, secs_left}, 32'd1);
    chk("rst_ns", 0, {29'd0, ns_light}, 32'h4);
    chk("rst_ew", 0, {29'd0, ew_light}, 32'h4);
    chk("rst_walk", 0, {31'd0, walk}, 32'd0);
    chk("rst_pend", 0, {31'd0, ped_pending}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].ped) pulse_ped();
      night_mode = vt[i].night;
      do_tick();
      chk("state", i, {29'd0, state_out}, {29'd0, vt[i].st});
      chk("secs", i, {26'd0, secs_left}, {26'd0, vt[i].sec});
      chk("ns", i, {29'd0, ns_light}, {29'd0, vt[i].ns});
      chk("ew", i, {29'd0, ew_light}, {29'd0, vt[i].ew});
      chk("walk", i, {31'd0, walk}, {31'd0, vt[i].wk});
      chk("pend", i, {31'd0, ped_pending}, {31'd0, vt[i].pd});
    end

    // Async reset mid NS_Y with a request pending.
    repeat (3) do_tick();
    chk("pre_rst_state", 0, {29'd0, state_out}, 32'd1);
    pulse_ped();
    chk("pre_rst_pend", 0, {31'd0, ped_pending}, 32'd1);
    @(posedge clk_in);
    #3 rst = 1'b1;
    #1;
    chk("arst_state", 0, {29'd0, state_out}, 32'd5);
    chk("arst_secs", 0, {26'd0, secs_left}, 32'd1);
    chk("arst_ns", 0, {29'd0, ns_light}, 32'h4);
    chk("arst_ew", 0, {29'd0, ew_light}, 32'h4);
    chk("arst_pend", 0, {31'd0, ped_pending}, 32'd0);
    @(negedge clk_in) rst = 1'b0;
    do_tick();
    chk("post_rst_state", 0, {29'd0, state_out}, 32'd0);
    chk("post_rst_secs", 0, {26'd0, secs_left}, 32'd3);

    // Tick held high: one state step per clock, durations in cycles.
    exp_seq = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd0};
    chk("fast_state", 0, {29'd0, state_out}, {29'd0, exp_seq[0]});
    sec_tick = 1'b1;
    for (int i = 1; i < 12; i++) begin
      @(negedge clk_in);
      chk("fast_state", i, {29'd0, state_out}, {29'd0, exp_seq[i]});
    end
    sec_tick = 1'b0;
    @(negedge clk_in);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
